// File: rtl/pq_request_frontend.sv
// Command frontend for the register-tree priority queue: turns enq/deq
// handshakes into one-cycle tree commands, then idles while the tree settles.
//
// Ports:
//   i_CLK, i_RST        clock, synchronous active-high reset
//   i_enq_valid/o_enq_ready/i_enq_data   enqueue request (data 0 is dropped)
//   i_deq_valid/o_deq_ready              dequeue request
//   o_rsp_valid/i_rsp_ready/o_rsp_data   dequeued old-root response
//   o_drop_zero         one-cycle pulse when a zero enqueue is discarded
//   o_busy              high while a command or settle window is in progress
//   o_pq_wrt/o_pq_read/o_pq_data         command to the tree
//   i_pq_full/i_pq_empty/i_pq_data       tree status and current root
module pq_request_frontend #(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 15,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_enq_valid,
  output logic                  o_enq_ready,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  input  logic                  i_deq_valid,
  output logic                  o_deq_ready,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_drop_zero,
  output logic                  o_busy,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    SETTLE
  } state_t;

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  wrt_nxt;
  logic                  read_nxt;
  logic [DATA_WIDTH-1:0] pqd_nxt;
  logic                  rspv_nxt;
  logic [DATA_WIDTH-1:0] rspd_nxt;
  logic                  drop_nxt;
  logic                  enq_fire;
  logic                  deq_fire;
  logic                  enq_zero;

  // A full tree still takes an enqueue when it is paired with a dequeue
  assign o_deq_ready = (state == IDLE) && !i_pq_empty && !o_rsp_valid;
  assign o_enq_ready = (state == IDLE) &&
                       (!i_pq_full || (i_deq_valid && o_deq_ready));

  assign enq_fire = i_enq_valid && o_enq_ready;
  assign deq_fire = i_deq_valid && o_deq_ready;
  assign enq_zero = (i_enq_data == '0);
  assign o_busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrt_nxt   = 1'b0;
    read_nxt  = 1'b0;
    pqd_nxt   = '0;
    rspv_nxt  = o_rsp_valid && !i_rsp_ready;
    rspd_nxt  = o_rsp_data;
    drop_nxt  = enq_fire && enq_zero;
    unique case (state)
      IDLE: begin
        if ((enq_fire && !enq_zero) || deq_fire) begin
          wrt_nxt   = enq_fire && !enq_zero;
          read_nxt  = deq_fire;
          pqd_nxt   = wrt_nxt ? i_enq_data : '0;
          state_nxt = CMD;
        end
      end
      CMD: begin
        // Root is still the pre-command value during this cycle
        if (o_pq_read) begin
          rspv_nxt = 1'b1;
          rspd_nxt = i_pq_data;
        end
        if (SETTLE_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= IDLE;
      cnt         <= '0;
      o_pq_wrt    <= 1'b0;
      o_pq_read   <= 1'b0;
      o_pq_data   <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_drop_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_pq_wrt    <= wrt_nxt;
      o_pq_read   <= read_nxt;
      o_pq_data   <= pqd_nxt;
      o_rsp_valid <= rspv_nxt;
      o_rsp_data  <= rspd_nxt;
      o_drop_zero <= drop_nxt;
    end
  end

  a_qsize: assert property (@(posedge i_CLK) QUEUE_SIZE > 0);

  a_wrt_full: assert property (@(posedge i_CLK) disable iff (i_RST)
    (o_pq_wrt && !o_pq_read) |-> !i_pq_full);

  a_read_empty: assert property (@(posedge i_CLK) disable iff (i_RST)
    o_pq_read |-> !i_pq_empty);

  a_wrt_data: assert property (@(posedge i_CLK) disable iff (i_RST)
    o_pq_wrt |-> (o_pq_data != '0));

endmodule

// File: doc/pq_request_frontend.md
Name: pq_request_frontend

Overview:
Upstream command stage for the register-tree priority queue. It accepts enqueue and dequeue requests on valid/ready interfaces and issues single-cycle i_wrt/i_read commands to the tree, merging a simultaneous enqueue and dequeue into one replace. After each command it holds an idle settle window so the tree can run its compare-and-swap passes. The dequeued root value is returned on a valid/ready response port.

Parameters:
DATA_WIDTH, 16, width of key/data; must match the tree.
QUEUE_SIZE, 15, tree capacity; informational, used only by assertions.
SETTLE_CYCLES, 4, idle cycles forced after each issued command; 0 is legal.

Ports:
i_CLK  input  1  clock; all state changes on the rising edge.
i_RST  input  1  synchronous, active-high reset.
i_enq_valid  input  1  enqueue request valid.
o_enq_ready  output  1  enqueue request accepted when valid and ready are both high.
i_enq_data  input  DATA_WIDTH  key to insert; 0 is reserved because the tree treats 0 as an empty slot.
i_deq_valid  input  1  dequeue request valid.
o_deq_ready  output  1  dequeue request accepted when valid and ready are both high.
o_rsp_valid  output  1  dequeued value available.
i_rsp_ready  input  1  downstream consumes the response.
o_rsp_data  output  DATA_WIDTH  dequeued (old root) value.
o_drop_zero  output  1  one-cycle pulse when an enqueue of 0 is consumed and discarded.
o_busy  output  1  high while in CMD or SETTLE.
o_pq_wrt  output  1  to tree i_wrt.
o_pq_read  output  1  to tree i_read.
o_pq_data  output  DATA_WIDTH  to tree i_data.
i_pq_full  input  1  from tree o_full.
i_pq_empty  input  1  from tree o_empty.
i_pq_data  input  DATA_WIDTH  from tree o_data (current root).

Behaviour:
- Clock and reset: one clock, i_CLK. Reset is synchronous and active-high on i_RST. Integration drives the tree's i_RSTn with the inverse of i_RST.
- Reset values: every output register is 0 (o_pq_*, o_rsp_valid, o_rsp_data, o_drop_zero); state is IDLE; settle counter is 0.
- Reset mid-operation: takes effect at the next edge. Any pending response or command is discarded and nothing is replayed.
- FSM states: IDLE, CMD, SETTLE.
- Ready logic:
  - o_deq_ready = IDLE && !i_pq_empty && !o_rsp_valid.
  - o_enq_ready = IDLE && (!i_pq_full || (i_deq_valid && o_deq_ready)). When full, enqueue is allowed only as half of a replace.
  - Both readies are 0 in CMD and SETTLE.
- Accept in IDLE; let enq_fire and deq_fire be the two handshakes:
  - enq_fire with data 0: consumed, o_drop_zero pulses for the next cycle, no tree command. If deq_fire in the same cycle, it proceeds as a plain dequeue.
  - enq_fire (nonzero) only: register o_pq_wrt=1, o_pq_data=i_enq_data; go to CMD.
  - deq_fire only: register o_pq_read=1; go to CMD.
  - Both (nonzero data): register o_pq_wrt=o_pq_read=1, o_pq_data=i_enq_data (replace). This is legal while full, and size is unchanged.
- CMD (exactly 1 cycle):
  - The tree sees the command during this cycle. If o_pq_read=1, capture o_rsp_data <= i_pq_data (old root) and set o_rsp_valid at the same edge.
  - Clear o_pq_wrt, o_pq_read and o_pq_data at the edge leaving CMD.
  - Next state is SETTLE with counter = SETTLE_CYCLES-1, or IDLE if SETTLE_CYCLES=0.
- SETTLE: all tree commands low; decrement the counter each cycle; go to IDLE when it reaches 0.
- Latency: accept at cycle T -> command visible T+1 -> o_rsp_valid at T+2 -> readies can be high again at T+2+SETTLE_CYCLES.
- Response: o_rsp_valid and o_rsp_data hold until o_rsp_valid && i_rsp_ready, which clears valid at the next edge. A response may drain in any state.
- Command outputs are never asserted outside CMD, and never for more than one cycle.
- Assertions: no o_pq_wrt-only command while i_pq_full; no o_pq_read while i_pq_empty; o_pq_data != 0 whenever o_pq_wrt=1.

Test Plan:
1. Hold i_RST=1 for 2 cycles, with i_pq_empty=1 and i_pq_full=0 -> all outputs 0; after release o_enq_ready=1 and o_deq_ready=0.
2. Enqueue data 5 accepted at T -> o_pq_wrt=1 and o_pq_data=5 only at T+1; o_busy=1 for T+1..T+5; o_enq_ready=1 again at T+6 (SETTLE_CYCLES=4).
3. Dequeue with i_pq_empty=0 and i_pq_data=9 at T+1, i_rsp_ready=0 -> o_pq_read=1 at T+1; o_rsp_valid=1 and o_rsp_data=9 from T+2 and held; o_deq_ready stays 0 until i_rsp_ready=1 drains the response.
4. Simultaneous enqueue 7 and dequeue with i_pq_full=1 and root 12 -> both readies high; at T+1 o_pq_wrt=o_pq_read=1 and o_pq_data=7; o_rsp_data=12.
5. Enqueue data 0 -> accepted; o_drop_zero=1 for one cycle; no o_pq_wrt; o_enq_ready=1 on the following cycle with no settle window.
6. Assert i_RST during SETTLE with a response pending -> next cycle o_rsp_valid=0, o_busy=0, state IDLE.
